hashvoodoo_stim_seq: RTL and testbench

Synthesizable, parametrised stimulus sequencer for the HashVoodoo miner top level, used in simulation and on-board self-test builds. After reset it waits a programmable settling time, serially loads a work packet onto the miner's RxD line, and issues staggered start-mining pulses to one or more hashing channels. It then waits for a reported nonce and flags pass or timeout.

---
 rtl/hashvoodoo_stim_seq_if.sv | 29 ++
 rtl/hashvoodoo_stim_seq.sv | 204 ++++++++++++++++++++
 tb/tb_hashvoodoo_stim_seq.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hashvoodoo_stim_seq_if.sv
// Host controls and miner-facing stimulus of hashvoodoo_stim_seq.
// 'master' is the host/test side that requests a run; 'slave' is the sequencer itself.
interface hashvoodoo_stim_seq_if #(
  parameter int unsigned NUM_CH     = 1,
  parameter int unsigned WORK_BYTES = 44
);
  logic                    enable;
  logic [WORK_BYTES*8-1:0] work_data;
  logic [31:0]             expected_nonce;
  logic                    nonce_valid;
  logic [31:0]             nonce;
  logic                    rxd;
  logic [NUM_CH-1:0]       start_mining;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic                    timeout;
  logic [7:0]              mismatch_cnt;

  modport master (
    output enable, work_data, expected_nonce, nonce_valid, nonce,
    input  rxd, start_mining, busy, done, pass, timeout, mismatch_cnt
  );

  modport slave (
    input  enable, work_data, expected_nonce, nonce_valid, nonce,
    output rxd, start_mining, busy, done, pass, timeout, mismatch_cnt
  );
endinterface

// File: rtl/hashvoodoo_stim_seq.sv
// HashVoodoo stimulus sequencer: settle, load the work packet serially on rxd, pulse
// start_mining per channel, then await the golden nonce. HV_STIM_PARITY_EN selects 8E1 framing.
module hashvoodoo_stim_seq #(
  parameter int unsigned NUM_CH         = 1,
  parameter int unsigned STARTUP_CYCLES = 10,
  parameter int unsigned WORK_BYTES     = 44,
  parameter int unsigned BAUD_DIV       = 16,
  parameter int unsigned STAGGER_CYCLES = 0,
  parameter int unsigned PULSE_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hashvoodoo_stim_seq_if.slave  bus
);

`ifdef HV_STIM_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int unsigned START_LEN = (NUM_CH - 1) * STAGGER_CYCLES + PULSE_CYCLES;
  localparam int unsigned CNT_MAX0  = (STARTUP_CYCLES > START_LEN) ? STARTUP_CYCLES : START_LEN;
  localparam int unsigned CNT_MAX   = (CNT_MAX0 > TIMEOUT_CYCLES) ? CNT_MAX0 : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned BAUD_W    = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W     = $clog2(FRAME_BITS);
  localparam int unsigned BYTE_W    = (WORK_BYTES > 1) ? $clog2(WORK_BYTES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_STARTUP, ST_SEND, ST_START, ST_WAIT, ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic                en_q;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic [7:0]          mm_q, mm_d;
  logic                rxd_q, rxd_d;
  logic [NUM_CH-1:0]   sm_q, sm_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          cur_byte;
  logic [BIT_W-1:0]    data_idx;
  logic                match;

  assign match = bus.nonce_valid && (bus.nonce == bus.expected_nonce);

  // NOTE: every variable gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    mm_d      = mm_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en_q) begin
          state_d   = ST_STARTUP;
          cnt_d     = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          mm_d      = '0;
        end
      end
      ST_STARTUP: begin
        if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
          state_d = ST_SEND;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (baud_q == BAUD_W'(BAUD_DIV - 1)) begin
          baud_d = '0;
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            bit_d = '0;
            if (byte_q == BYTE_W'(WORK_BYTES - 1)) begin
              state_d = ST_START;
              cnt_d   = '0;
            end else begin
              byte_d = byte_q + BYTE_W'(1);
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_START: begin
        if (cnt_q == CNT_W'(START_LEN - 1)) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        // A match on the terminal timeout cycle wins over the timeout.
        if (match) begin
          pass_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          if (bus.nonce_valid && (mm_q != 8'hFF)) mm_d = mm_q + 8'd1;
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (!en_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    cur_byte = 8'(bus.work_data >> {byte_d, 3'b000});
    data_idx = bit_d - BIT_W'(1);
    rxd_d    = 1'b1;
    if (state_d == ST_SEND) begin
      if (bit_d == '0) begin
        rxd_d = 1'b0;
      end else if (bit_d == BIT_W'(FRAME_BITS - 1)) begin
        rxd_d = 1'b1;
`ifdef HV_STIM_PARITY_EN
      end else if (bit_d == BIT_W'(9)) begin
        rxd_d = ^cur_byte;
`endif
      end else begin
        rxd_d = cur_byte[data_idx[2:0]];
      end
    end

    sm_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sm_d[i] = (state_d == ST_START)
             && (32'(cnt_d) >= i * STAGGER_CYCLES)
             && (32'(cnt_d) <  i * STAGGER_CYCLES + PULSE_CYCLES);
    end

    busy_d = (state_d == ST_STARTUP) || (state_d == ST_SEND)
          || (state_d == ST_START)   || (state_d == ST_WAIT);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      en_q      <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      mm_q      <= '0;
      rxd_q     <= 1'b1;
      sm_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      en_q      <= bus.enable;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      mm_q      <= mm_d;
      rxd_q     <= rxd_d;
      sm_q      <= sm_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.rxd          = rxd_q;
  assign bus.start_mining = sm_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.timeout      = timeout_q;
  assign bus.mismatch_cnt = mm_q;

endmodule

// File: tb/tb_hashvoodoo_stim_seq.sv
// Bench for hashvoodoo_stim_seq: a timeline model of the run checks every output each cycle,
// and hand-computed latencies and bit patterns pin that model.
module tb_hashvoodoo_stim_seq;
  localparam int NC = 3, SU = 10, WB = 2, BD = 4, ST = 2, PW = 3, TO = 20;
`ifdef HV_STIM_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int SEND_LEN  = WB * FB * BD;
  localparam int START_LEN = (NC - 1) * ST + PW;
  localparam logic [15:0] WORK = 16'hA55A;
  localparam logic [31:0] GOLD = 32'h0000_1234;

  localparam int W_BUSY = 0, W_RXD = 1, W_SM0 = 2, W_DONE = 3, W_TO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  hashvoodoo_stim_seq_if #(.NUM_CH(NC), .WORK_BYTES(WB)) bus ();

  hashvoodoo_stim_seq #(
    .NUM_CH(NC), .STARTUP_CYCLES(SU), .WORK_BYTES(WB), .BAUD_DIV(BD),
    .STAGGER_CYCLES(ST), .PULSE_CYCLES(PW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial image of the packet: bit j of the whole SEND phase.
  function automatic logic frame_bit(input int j);
    int b, p;
    logic [7:0] by;
    b  = j / FB;
    p  = j % FB;
    by = 8'(WORK >> (8 * b));
    if (p == 0) return 1'b0;
    if (p <= 8) return by[p-1];
    if (FB == 11 && p == 9) return ^by;
    return 1'b1;
  endfunction

  // Run timeline: m_s = first busy cycle, m_w = WAIT entry edge, m_d = DONE edge (-1 while pending).
  bit m_run = 1'b0, m_pass = 1'b0, m_to = 1'b0, en_prev = 1'b0;
  int m_s = 0, m_w = 0, m_d = -1, m_mm = 0;

  always @(posedge clk or negedge reset_n) begin : model
    int c;
    if (!reset_n) begin
      m_run <= 1'b0; m_pass <= 1'b0; m_to <= 1'b0; m_mm <= 0; m_d <= -1; en_prev <= 1'b0;
    end else begin
      c = cyc + 1;
      cyc <= c;
      if (!m_run) begin
        if (en_prev) begin
          m_run <= 1'b1; m_s <= c; m_w <= c + SU + SEND_LEN + START_LEN;
          m_d <= -1; m_pass <= 1'b0; m_to <= 1'b0; m_mm <= 0;
        end
      end else if (m_d < 0) begin
        if (c > m_w && c <= m_w + TO) begin
          if (bus.nonce_valid && bus.nonce == bus.expected_nonce) begin
            m_d <= c; m_pass <= 1'b1;
          end else begin
            if (bus.nonce_valid && m_mm < 255) m_mm <= m_mm + 1;
            if (c == m_w + TO) begin m_d <= c; m_to <= 1'b1; end
          end
        end
      end else if (c > m_d && !en_prev) begin
        m_run <= 1'b0;
      end
      en_prev <= bus.enable;
    end
  end

  always @(negedge clk) begin : compare
    logic e_busy, e_done, e_rxd;
    logic [NC-1:0] e_sm;
    int p;
    if (chk_on) begin
      e_busy = m_run && (m_d < 0 || cyc < m_d);
      e_done = m_run && m_d >= 0 && cyc >= m_d;
      e_rxd  = 1'b1;
      if (m_run && cyc >= m_s + SU && cyc < m_s + SU + SEND_LEN)
        e_rxd = frame_bit((cyc - m_s - SU) / BD);
      for (int i = 0; i < NC; i++) begin
        p = m_s + SU + SEND_LEN + i * ST;
        e_sm[i] = m_run && cyc >= p && cyc < p + PW;
      end
      check("cmp_rxd",     32'(bus.rxd),          32'(e_rxd));
      check("cmp_start",   32'(bus.start_mining), 32'(e_sm));
      check("cmp_busy",    32'(bus.busy),         32'(e_busy));
      check("cmp_done",    32'(bus.done),         32'(e_done));
      check("cmp_pass",    32'(bus.pass),         32'(m_pass));
      check("cmp_timeout", 32'(bus.timeout),      32'(m_to));
      check("cmp_mm",      32'(bus.mismatch_cnt), 32'(m_mm));
    end
  end

  function automatic logic sig(input int w);
    case (w)
      W_BUSY:  return bus.busy;
      W_RXD:   return bus.rxd;
      W_SM0:   return bus.start_mining[0];
      W_DONE:  return bus.done;
      W_TO:    return bus.timeout;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) at falling edges until the selected output reaches val.
  task automatic wait_neg(input string name, input int w, input logic val, input int limit,
                          output int at);
    int k;
    k = 0;
    @(negedge clk);
    while (sig(w) !== val && k < limit) begin
      @(negedge clk);
      k++;
    end
    at = cyc;
    check(name, 32'(sig(w)), 32'(val));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, f, p, t, m;
    int rise [NC];
    int hcnt [NC];
    logic [31:0] got, want;

    bus.enable = 1'b0; bus.nonce_valid = 1'b0; bus.nonce = '0;
    bus.expected_nonce = GOLD; bus.work_data = WORK;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rxd",   32'(bus.rxd), 32'd1);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_start", 32'(bus.start_mining), 32'd0);
    check("rst_flags", 32'({bus.done, bus.pass, bus.timeout}), 32'd0);
    check("rst_mm",    32'(bus.mismatch_cnt), 32'd0);
    chk_on = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (50) tick();
    check("idle_rxd",  32'(bus.rxd), 32'd1);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Run A: serial image, stagger, mismatch then match.
    tick();
    bus.enable = 1'b1;
    n = cyc + 1;
    wait_neg("a_busy", W_BUSY, 1'b1, 20, t);
    check("a_busy_lat", t - n, 32'd1);
    wait_neg("a_rxd", W_RXD, 1'b0, 40, f);
    check("a_rxd_lat", f - n, 32'd11);
    got = '0;
    for (int j = 0; j < FB * WB; j++) begin
      if (j == 0) @(negedge clk);
      else repeat (BD) @(negedge clk);
      got[j] = bus.rxd;
    end
`ifdef HV_STIM_PARITY_EN
    want = 32'h002A_54B4;
`else
    want = 32'h000D_2AB4;
`endif
    check("a_rxd_bits", got, want);
    wait_neg("a_sm0", W_SM0, 1'b1, 40, p);
`ifdef HV_STIM_PARITY_EN
    check("a_send_len", p - f, 32'd88);
`else
    check("a_send_len", p - f, 32'd80);
`endif
    for (int i = 0; i < NC; i++) begin rise[i] = -1; hcnt[i] = 0; end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if (bus.start_mining[i]) begin
          hcnt[i]++;
          if (rise[i] < 0) rise[i] = cyc - p;
        end
      end
    end
    check("a_rise1", rise[1], 32'd2);
    check("a_rise2", rise[2], 32'd4);
    check("a_width0", hcnt[0], 32'd3);
    check("a_width2", hcnt[2], 32'd3);
    tick();
    bus.nonce = 32'hDEAD_BEEF; bus.nonce_valid = 1'b1;
    tick();
    bus.nonce_valid = 1'b0;
    tick();
    bus.nonce = GOLD; bus.nonce_valid = 1'b1;
    m = cyc + 1;
    check("a_pass_early", 32'(bus.pass), 32'd0);
    tick();
    bus.nonce_valid = 1'b0;
    check("a_pass_edge", cyc - m, 32'd0);
    check("a_pass", 32'(bus.pass), 32'd1);
    check("a_done", 32'(bus.done), 32'd1);
    check("a_timeout", 32'(bus.timeout), 32'd0);
    check("a_mm", 32'(bus.mismatch_cnt), 32'd1);
    repeat (6) tick();
    check("a_hold_done", 32'(bus.done), 32'd1);
    check("a_hold_busy", 32'(bus.busy), 32'd0);
    bus.enable = 1'b0;
    repeat (5) tick();
    check("a_idle_done", 32'(bus.done), 32'd0);
    check("a_idle_pass", 32'(bus.pass), 32'd1);

    // Run B: enable dropped early, stray nonce during SEND, no answer -> timeout.
    tick();
    bus.enable = 1'b1;
    repeat (4) tick();
    bus.enable = 1'b0;
    check("b_pass_clr", 32'(bus.pass), 32'd0);
    wait_neg("b_rxd", W_RXD, 1'b0, 40, f);
    tick();
    bus.nonce = 32'hDEAD_BEEF; bus.nonce_valid = 1'b1;
    tick();
    bus.nonce_valid = 1'b0;
    wait_neg("b_sm0", W_SM0, 1'b1, 120, p);
    wait_neg("b_to", W_TO, 1'b1, 100, t);
    check("b_to_lat", t - p, 32'd27);
    check("b_done", 32'(bus.done), 32'd1);
    check("b_pass", 32'(bus.pass), 32'd0);
    check("b_mm", 32'(bus.mismatch_cnt), 32'd0);
    repeat (4) tick();
    check("b_idle_to", 32'(bus.timeout), 32'd1);

    // Run C: matching nonce on the terminal timeout cycle.
    tick();
    bus.enable = 1'b1;
    wait_neg("c_sm0", W_SM0, 1'b1, 200, p);
    while (cyc < p + 26) @(negedge clk);
    bus.nonce = GOLD; bus.nonce_valid = 1'b1;
    @(negedge clk);
    bus.nonce_valid = 1'b0;
    check("c_pass", 32'(bus.pass), 32'd1);
    check("c_timeout", 32'(bus.timeout), 32'd0);
    check("c_done", 32'(bus.done), 32'd1);
    bus.enable = 1'b0;
    repeat (4) tick();

    // Abort: reset mid-SEND, then restart from STARTUP.
    tick();
    bus.enable = 1'b1;
    wait_neg("d_rxd", W_RXD, 1'b0, 40, f);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("d_abort_rxd", 32'(bus.rxd), 32'd1);
    check("d_abort_busy", 32'(bus.busy), 32'd0);
    tick();
    reset_n = 1'b1;
    n = cyc + 1;
    wait_neg("d_busy", W_BUSY, 1'b1, 20, t);
    check("d_busy_lat", t - n, 32'd1);
    wait_neg("d_rxd2", W_RXD, 1'b0, 40, f);
    check("d_rxd_lat", f - n, 32'd11);
    bus.enable = 1'b0;
    wait_neg("d_done", W_DONE, 1'b1, 200, t);
    check("d_timeout", 32'(bus.timeout), 32'd1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
